uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter STOP_BITS, default 1, meaning number of stop bits per frame; legal values are 1 and 2.
REQ-002 Parameter PARITY, default 0, meaning parity mode: 0 none, 1 even, 2 odd.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 tick  input  1  one-cycle bit-period strobe from the external baud tick generator.
REQ-006 baud_en  output  1  enable to the baud tick generator; low reloads the generator's phase.
REQ-007 req0_valid  input  1  requester 0 holds a byte for transmission.
REQ-008 req0_data  input  8  requester 0 byte.
REQ-009 req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-010 req1_valid, req1_data[7:0], req1_ready SHALL mirror REQ-007..REQ-009 for requester 1.
REQ-011 txd  output  1  serial line, idle high.
REQ-012 busy  output  1  frame in progress (state not IDLE).
REQ-013 grant_id  output  1  requester owning the current or last frame.

Function
REQ-014 The block SHALL implement states IDLE, START, DATA, PAR, STOP.
REQ-015 An accept slot SHALL exist in IDLE, and in STOP on the tick that ends the final stop bit.
REQ-016 In an accept slot with any valid high, the block SHALL grant one requester and drive its ready high combinationally for that single cycle; the other ready SHALL stay low.
REQ-017 Arbitration SHALL be round-robin: if both are valid, grant the requester not granted last; if one is valid, grant it.
REQ-018 The last-granted pointer SHALL reset to 1, so requester 0 wins the first contention.
REQ-019 On accept, the block SHALL latch the data byte and grant_id, and enter START on the next edge.
REQ-020 Requesters SHALL hold valid and data stable until ready; the block SHALL never accept while in START, DATA or PAR.
REQ-021 baud_en SHALL be registered: high in START, DATA, PAR and STOP; low in IDLE.
REQ-022 The START output SHALL be txd=0 and SHALL be held until the next tick.
REQ-023 DATA SHALL send 8 bits LSB first, one bit per tick, using a 3-bit index.
REQ-024 After bit 7's tick, the block SHALL enter PAR if PARITY is not 0, else STOP.
REQ-025 The PAR bit SHALL be the XOR of the 8 data bits for even parity, and its inverse for odd parity.
REQ-026 STOP SHALL drive txd=1 for STOP_BITS ticks.
REQ-027 On the final stop tick, the block SHALL go to START if a grant occurs that cycle (baud_en stays high, no idle gap), else to IDLE.
REQ-028 tick SHALL be ignored in IDLE.
REQ-029 Each state SHALL advance only on tick.
REQ-030 txd SHALL be registered and glitch-free.
REQ-031 Frame length SHALL be exactly 10, 11 or 12 ticks, as set by PARITY and STOP_BITS.

Reset
REQ-032 While rst_n is low: txd=1, baud_en=0, busy=0, state IDLE, bit index 0, grant_id=0, last-granted pointer=1, both readies forced 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately (txd=1 asynchronously); the byte is lost and is not re-requested.
REQ-034 After rst_n deasserts, the first accept slot SHALL be the first rising edge with rst_n high.

Verification
REQ-035 Single byte: req0 sends 0xA5, PARITY=0, STOP_BITS=1 -> one ready pulse; txd per tick is 0,1,0,1,0,0,1,0,1,1; baud_en low after the frame.
REQ-036 Contention: both valid from reset with bytes 0x11 and 0x22 -> 0x11 sent first with grant_id=0, then 0x22 with grant_id=1, and no idle cycle between the stop bit and the next start bit.
REQ-037 Parity: PARITY=2, byte 0x07 -> parity bit 0; PARITY=1, byte 0x07 -> parity bit 1; frame is 11 ticks.
REQ-038 STOP_BITS=2 with req1 continuously valid -> 11-tick frames; grant stays on 1; ready pulses once per frame.
REQ-039 Reset is pulsed during DATA bit 3 -> txd=1 and baud_en=0 in the same cycle; the next frame starts cleanly with requester 0 priority.
REQ-040 A tick is driven while IDLE with no valid -> txd stays 1, busy stays 0, no ready pulse.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-requester round-robin UART frame transmitter.
// Frames are start bit, 8 data bits LSB first, optional parity bit and
// STOP_BITS stop bits. Bit timing comes from an external baud tick
// generator. baud_en holds that generator in phase reload while idle.
module uart_tx_sched #(
  parameter int STOP_BITS = 1,
  parameter int PARITY    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  output logic       baud_en,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       txd,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t     r_state;
  logic [2:0] r_idx;
  logic       r_stop_cnt;
  logic [7:0] r_data;
  logic       r_last;
  logic       r_txd;
  logic       r_baud_en;
  logic       r_gid;

  logic       w_last_stop;
  logic       w_slot;
  logic       w_pick1;
  logic       w_grant;
  logic [7:0] w_data;
  logic       w_par;

  // Accept-slot detection, round-robin pick and parity of the latched byte.
  always_comb begin
    w_last_stop = (STOP_BITS == 2) ? r_stop_cnt : 1'b1;
    w_slot      = rst_n && ((r_state == IDLE) ||
                            ((r_state == STOP) && tick && w_last_stop));
    w_pick1     = req1_valid && (!req0_valid || !r_last);
    w_grant     = w_slot && (req0_valid || req1_valid);
    w_data      = w_pick1 ? req1_data : req0_data;
    w_par       = (^r_data) ^ (PARITY == 2);
  end

  assign req0_ready = w_grant && !w_pick1;
  assign req1_ready = w_grant && w_pick1;
  assign txd        = r_txd;
  assign baud_en    = r_baud_en;
  assign busy       = (r_state != IDLE);
  assign grant_id   = r_gid;

  // Frame sequencer with registered line and baud-enable outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_stop_cnt <= 1'b0;
      r_data     <= '0;
      r_last     <= 1'b1;
      r_txd      <= 1'b1;
      r_baud_en  <= 1'b0;
      r_gid      <= 1'b0;
    end else if (w_grant) begin
      // Grants only occur in IDLE or on the final stop tick, so both
      // accept paths share this branch ahead of the per-state logic.
      r_state    <= START;
      r_data     <= w_data;
      r_gid      <= w_pick1;
      r_last     <= w_pick1;
      r_idx      <= '0;
      r_stop_cnt <= 1'b0;
      r_txd      <= 1'b0;
      r_baud_en  <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_txd     <= 1'b1;
          r_baud_en <= 1'b0;
        end
        START: begin
          if (tick) begin
            r_state <= DATA;
            r_idx   <= '0;
            r_txd   <= r_data[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (r_idx == 3'd7) begin
              if (PARITY != 0) begin
                r_state <= PAR;
                r_txd   <= w_par;
              end else begin
                r_state    <= STOP;
                r_stop_cnt <= 1'b0;
                r_txd      <= 1'b1;
              end
            end else begin
              r_idx <= r_idx + 3'd1;
              r_txd <= r_data[r_idx + 3'd1];
            end
          end
        end
        PAR: begin
          if (tick) begin
            r_state    <= STOP;
            r_stop_cnt <= 1'b0;
            r_txd      <= 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            if (w_last_stop) begin
              r_state   <= IDLE;
              r_baud_en <= 1'b0;
              r_txd     <= 1'b1;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_txd     <= 1'b1;
          r_baud_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: four instances covering parity and
// stop-bit variants, random tick spacing, queue-fed requesters and a
// frame-level reference model.
module tb_uart_tx_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] baud_en, txd, busy, gid, rdy0, rdy1;
  logic [3:0] v0 = '0;
  logic [3:0] v1 = '0;
  logic [7:0] d0 [4];
  logic [7:0] d1 [4];

  int checks = 0;
  int errors = 0;

  logic [7:0] q0m [4][64];
  logic [7:0] q1m [4][64];
  int q0h [4], q0t [4], q1h [4], q1t [4], b0s [4], b1s [4];
  logic       gotb [4][512];
  int         gotn [4];
  logic [7:0] gotd [4][64];
  logic       gotw [4][64];
  logic       gotgid [4][64];
  int         gotgn [4], gidn [4], gaps [4];
  logic       pend [4], started [4], mlast [4];

  always #5 clk = ~clk;

  uart_tx_sched #(.STOP_BITS(1), .PARITY(0)) u0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .baud_en(baud_en[0]),
    .req0_valid(v0[0]), .req0_data(d0[0]), .req0_ready(rdy0[0]),
    .req1_valid(v1[0]), .req1_data(d1[0]), .req1_ready(rdy1[0]),
    .txd(txd[0]), .busy(busy[0]), .grant_id(gid[0]));
  uart_tx_sched #(.STOP_BITS(1), .PARITY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .baud_en(baud_en[1]),
    .req0_valid(v0[1]), .req0_data(d0[1]), .req0_ready(rdy0[1]),
    .req1_valid(v1[1]), .req1_data(d1[1]), .req1_ready(rdy1[1]),
    .txd(txd[1]), .busy(busy[1]), .grant_id(gid[1]));
  uart_tx_sched #(.STOP_BITS(1), .PARITY(2)) u2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .baud_en(baud_en[2]),
    .req0_valid(v0[2]), .req0_data(d0[2]), .req0_ready(rdy0[2]),
    .req1_valid(v1[2]), .req1_data(d1[2]), .req1_ready(rdy1[2]),
    .txd(txd[2]), .busy(busy[2]), .grant_id(gid[2]));
  uart_tx_sched #(.STOP_BITS(2), .PARITY(0)) u3 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .baud_en(baud_en[3]),
    .req0_valid(v0[3]), .req0_data(d0[3]), .req0_ready(rdy0[3]),
    .req1_valid(v1[3]), .req1_data(d1[3]), .req1_ready(rdy1[3]),
    .txd(txd[3]), .busy(busy[3]), .grant_id(gid[3]));

  function automatic int cfg_par(input int k);
    return (k == 1) ? 1 : (k == 2) ? 2 : 0;
  endfunction

  function automatic int cfg_stop(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Random-spaced baud ticks (1..4 cycles apart), driven away from the edge.
  initial begin
    int gap;
    gap = 1;
    forever begin
      @(posedge clk);
      #1;
      gap--;
      if (gap == 0) begin
        tick = 1'b1;
        gap  = $urandom_range(1, 4);
      end else begin
        tick = 1'b0;
      end
    end
  end

  // Requesters present the head of their queue until it is accepted.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        v0[k] = (q0h[k] != q0t[k]);
        v1[k] = (q1h[k] != q1t[k]);
        d0[k] = v0[k] ? q0m[k][q0h[k]] : 8'h00;
        d1[k] = v1[k] ? q1m[k][q1h[k]] : 8'h00;
      end
    end
  end

  // Monitor: line bits on ticks while busy, grants, grant_id and idle gaps.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (pend[k]) begin
          gotgid[k][gidn[k]] = gid[k];
          gidn[k]++;
          pend[k] = 1'b0;
        end
        if (busy[k] && tick && gotn[k] < 512) begin
          gotb[k][gotn[k]] = txd[k];
          gotn[k]++;
        end
        if (started[k] && !busy[k] && (q0h[k] != q0t[k] || q1h[k] != q1t[k]))
          gaps[k]++;
        if (rdy0[k] || rdy1[k]) begin
          chk($sformatf("rdy_excl%0d", k), rdy0[k] & rdy1[k], 0);
          chk($sformatf("rdy_slot%0d", k), busy[k] && !tick, 0);
          chk($sformatf("rdy_valid%0d", k), (rdy0[k] && !v0[k]) || (rdy1[k] && !v1[k]), 0);
          if (gotgn[k] < 64) begin
            gotd[k][gotgn[k]] = rdy0[k] ? d0[k] : d1[k];
            gotw[k][gotgn[k]] = !rdy0[k];
            gotgn[k]++;
          end
          if (rdy0[k]) q0h[k]++;
          else q1h[k]++;
          pend[k]    = 1'b1;
          started[k] = 1'b1;
        end
      end
    end
  end

  task automatic begin_batch();
    for (int k = 0; k < 4; k++) begin
      b0s[k] = q0t[k]; b1s[k] = q1t[k];
      gotn[k] = 0; gotgn[k] = 0; gidn[k] = 0; gaps[k] = 0;
      pend[k] = 1'b0; started[k] = 1'b0;
    end
  endtask

  task automatic push0(input logic [7:0] b);
    for (int k = 0; k < 4; k++) begin
      q0m[k][q0t[k]] = b;
      q0t[k]++;
    end
  endtask

  task automatic push1(input logic [7:0] b);
    for (int k = 0; k < 4; k++) begin
      q1m[k][q1t[k]] = b;
      q1t[k]++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int  n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
      done = (busy == 4'h0);
      for (int k = 0; k < 4; k++)
        if (q0h[k] != q0t[k] || q1h[k] != q1t[k]) done = 1'b0;
    end
    if (!done) chk({tag, "_timeout"}, 1, 0);
    repeat (2) @(posedge clk);
  endtask

  // Reference: round-robin over the batch's queued bytes, frames built from
  // start bit, data LSB first, optional parity and stop bits.
  task automatic check_batch(input string tag);
    logic       eb [512];
    logic [7:0] ed [64];
    logic       eid [64];
    int         i0, i1, ng, nb, par, nstop;
    logic       last, pick1;
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      i0 = b0s[k]; i1 = b1s[k]; ng = 0; nb = 0; last = mlast[k];
      par = cfg_par(k); nstop = cfg_stop(k);
      while (i0 < q0t[k] || i1 < q1t[k]) begin
        if (i0 < q0t[k] && i1 < q1t[k]) pick1 = !last;
        else pick1 = (i1 < q1t[k]);
        if (pick1) begin b = q1m[k][i1]; i1++; end
        else begin b = q0m[k][i0]; i0++; end
        ed[ng] = b; eid[ng] = pick1; ng++; last = pick1;
        eb[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin eb[nb] = b[i]; nb++; end
        if (par != 0) begin eb[nb] = (^b) ^ (par == 2); nb++; end
        for (int i = 0; i < nstop; i++) begin eb[nb] = 1'b1; nb++; end
      end
      mlast[k] = last;
      chk($sformatf("%s_ngrant%0d", tag, k), gotgn[k], ng);
      chk($sformatf("%s_ngid%0d", tag, k), gidn[k], ng);
      for (int i = 0; i < ng && i < gotgn[k] && i < gidn[k]; i++) begin
        chk($sformatf("%s_byte%0d_%0d", tag, k, i), gotd[k][i], ed[i]);
        chk($sformatf("%s_who%0d_%0d", tag, k, i), gotw[k][i], eid[i]);
        chk($sformatf("%s_gid%0d_%0d", tag, k, i), gotgid[k][i], eid[i]);
      end
      chk($sformatf("%s_nbits%0d", tag, k), gotn[k], nb);
      for (int i = 0; i < nb && i < gotn[k]; i++)
        chk($sformatf("%s_bit%0d_%0d", tag, k, i), gotb[k][i], eb[i]);
      chk($sformatf("%s_gaps%0d", tag, k), gaps[k], 0);
      chk($sformatf("%s_baud_after%0d", tag, k), baud_en[k], 0);
      chk($sformatf("%s_txd_after%0d", tag, k), txd[k], 1);
    end
  endtask

  initial begin
    logic [9:0] a5_pat;
    int n, n0, n1, rcnt;
    for (int k = 0; k < 4; k++) begin
      q0h[k] = 0; q0t[k] = 0; q1h[k] = 0; q1t[k] = 0;
      mlast[k] = 1'b1;
    end
    begin_batch();

    // Reset with both requesters already valid.
    push0(8'h11);
    push1(8'h22);
    repeat (3) @(posedge clk);
    #3;
    chk("rst_txd", txd, 4'hF);
    chk("rst_baud", baud_en, 4'h0);
    chk("rst_busy", busy, 4'h0);
    chk("rst_gid", gid, 4'h0);
    chk("rst_rdy", {rdy0, rdy1}, 8'h00);
    chk("rst_valid_seen", {v0, v1}, 8'hFF);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("first_slot_rdy0", rdy0, 4'hF);
    chk("first_slot_rdy1", rdy1, 4'h0);
    wait_idle("contend");
    check_batch("contend");
    chk("contend_first", gotd[0][0], 8'h11);
    chk("contend_second", gotd[0][1], 8'h22);

    // Single byte 0xA5 on requester 0.
    @(negedge clk); #1;
    begin_batch();
    push0(8'hA5);
    wait_idle("a5");
    check_batch("a5");
    a5_pat = 10'b1101001010;
    chk("a5_len", gotn[0], 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("a5_pat%0d", i), gotb[0][i], a5_pat[i]);

    // Parity on 0x07.
    @(negedge clk); #1;
    begin_batch();
    push0(8'h07);
    wait_idle("par");
    check_batch("par");
    chk("par_even_len", gotn[1], 11);
    chk("par_even_bit", gotb[1][9], 1);
    chk("par_odd_len", gotn[2], 11);
    chk("par_odd_bit", gotb[2][9], 0);

    // Requester 1 continuously valid.
    @(negedge clk); #1;
    begin_batch();
    for (int i = 0; i < 4; i++) push1(8'($urandom));
    wait_idle("r1cont");
    check_batch("r1cont");
    chk("r1cont_len3", gotn[3], 44);
    chk("r1cont_rdy", gotgn[3], 4);

    // Randomized batches.
    for (int r = 0; r < 6; r++) begin
      @(negedge clk); #1;
      begin_batch();
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      for (int i = 0; i < n0; i++) push0(8'($urandom));
      for (int i = 0; i < n1; i++) push1(8'($urandom));
      wait_idle("rnd");
      check_batch($sformatf("rnd%0d", r));
    end

    // Idle ticks with nothing valid.
    rcnt = 0;
    for (int t = 0; t < 3; t++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!tick && n < 20);
      if (!tick) chk("idle_tick_timeout", 1, 0);
      chk("idle_txd", txd, 4'hF);
      chk("idle_busy", busy, 4'h0);
      chk("idle_rdy", {rdy0, rdy1}, 8'h00);
    end

    // Reset pulsed during data bit 3.
    @(negedge clk); #1;
    begin_batch();
    push0(8'h00);
    n = 0;
    do begin @(posedge clk); #3; n++; end while (gotn[0] < 4 && n < 500);
    if (gotn[0] < 4) chk("midrst_timeout", 1, 0);
    chk("midrst_pre_baud", baud_en, 4'hF);
    chk("midrst_pre_txd", txd, 4'h0);
    rst_n = 1'b0;
    #1;
    chk("midrst_txd", txd, 4'hF);
    chk("midrst_baud", baud_en, 4'h0);
    chk("midrst_busy", busy, 4'h0);
    for (int k = 0; k < 4; k++) mlast[k] = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk); #1;
    begin_batch();
    push0(8'h33);
    push1(8'h44);
    wait_idle("postrst");
    check_batch("postrst");
    chk("postrst_first", gotd[0][0], 8'h33);
    chk("postrst_gid", gotgid[0][0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
